// File: rtl/spike_mac_pkg.sv
// Shared definitions for the spike-gated MAC unit.
//   state_t        : timestep controller states (ACCUM, FLUSH, HOLD)
//   psum_width()   : width of one beat's partial sum, W_WIDTH + clog2(N_SYN)
//   sat_max_bits() : bit pattern of the largest signed value of a given width
//   sat_min_bits() : bit pattern of the most negative signed value of a given width
// The saturation helpers return a 128-bit pattern whose low acc_w bits
// hold the limit; callers size-cast the result to their accumulator width.
package spike_mac_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int psum_width(input int n_syn, input int w_width);
    return w_width + $clog2(n_syn);
  endfunction

  function automatic logic [127:0] sat_max_bits(input int acc_w);
    return (128'd1 << (acc_w - 1)) - 128'd1;
  endfunction

  function automatic logic [127:0] sat_min_bits(input int acc_w);
    return 128'd1 << (acc_w - 1);
  endfunction

endpackage

// File: rtl/spike_mac_accum_if.sv
// Beat-in / result-out bus of the spike-gated MAC unit.
//   in_valid/in_ready/in_last : beat handshake, in_last marks end of timestep
//   spike_in [N_SYN]          : per-lane spike gate
//   weight [N_SYN*W_WIDTH]    : lane i weight at [i*W_WIDTH +: W_WIDTH]
//   out_valid/out_ready       : result handshake
//   out_sum [ACC_WIDTH]       : signed accumulated sum for the timestep
//   out_sat                   : accumulator saturated during the timestep
// master = beat producer / result consumer, slave = the MAC unit.
interface spike_mac_accum_if #(
  parameter int N_SYN     = 4,
  parameter int W_WIDTH   = 32,
  parameter int ACC_WIDTH = 40
);
  logic                       in_valid;
  logic                       in_ready;
  logic                       in_last;
  logic [N_SYN-1:0]           spike_in;
  logic [N_SYN*W_WIDTH-1:0]   weight;
  logic                       out_valid;
  logic                       out_ready;
  logic [ACC_WIDTH-1:0]       out_sum;
  logic                       out_sat;

  modport master (
    output in_valid, in_last, spike_in, weight, out_ready,
    input  in_ready, out_valid, out_sum, out_sat
  );

  modport slave (
    input  in_valid, in_last, spike_in, weight, out_ready,
    output in_ready, out_valid, out_sum, out_sat
  );
endinterface

// File: rtl/spike_mask_adder.sv
// Combinational spike masking and lane summation.
//   spike_in [N_SYN]        : lane gates
//   weight [N_SYN*W_WIDTH]  : signed lane weights
//   psum [PSUM_W]           : signed sum of the weights whose spike is set
// PSUM_W = W_WIDTH + clog2(N_SYN) holds the sum of all lanes without overflow.
module spike_mask_adder
  import spike_mac_pkg::*;
#(
  parameter int N_SYN   = 4,
  parameter int W_WIDTH = 32,
  localparam int PSUM_W = psum_width(N_SYN, W_WIDTH)
) (
  input  logic [N_SYN-1:0]         spike_in,
  input  logic [N_SYN*W_WIDTH-1:0] weight,
  output logic signed [PSUM_W-1:0] psum
);

  logic signed [PSUM_W-1:0] lane_term [N_SYN];

  // Gated lanes contribute zero; surviving weights are sign-extended first.
  always_comb begin
    for (int i = 0; i < N_SYN; i++) begin
      lane_term[i] = '0;
      if (spike_in[i]) begin
        lane_term[i] = PSUM_W'($signed(weight[i*W_WIDTH +: W_WIDTH]));
      end
    end
  end

  always_comb begin
    psum = '0;
    for (int i = 0; i < N_SYN; i++) begin
      psum = psum + lane_term[i];
    end
  end

endmodule

// File: rtl/spike_mac_accum.sv
// Spike-gated multiply-accumulate unit for the neuron core.
// Beats of N_SYN spikes plus weights are masked and summed (stage 1,
// registered), then added into a timestep accumulator (stage 2). The last
// beat of a timestep drains through FLUSH and the result is presented in
// HOLD until the consumer takes it; the handshake clears the accumulator.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spike_mac_accum_if.slave (beat input, result output)
// Optional feature macro SPIKE_MAC_SAT_EN: when defined, stage-2 addition
// saturates to the signed ACC_WIDTH limits and out_sat is a sticky flag;
// when undefined the addition wraps and out_sat is constant 0.
module spike_mac_accum
  import spike_mac_pkg::*;
#(
  parameter int N_SYN     = 4,
  parameter int W_WIDTH   = 32,
  parameter int ACC_WIDTH = 40
) (
  input  logic              clk,
  input  logic              rst,
  spike_mac_accum_if.slave  bus
);

  localparam int PSUM_W = psum_width(N_SYN, W_WIDTH);

  state_t                      state;
  logic                        in_ready_r;
  logic                        out_valid_r;
  logic                        accept_p0;
  logic signed [PSUM_W-1:0]    psum_p0;
  logic signed [PSUM_W-1:0]    psum_p1;
  logic                        vld_p1;
  logic                        last_p1;
  logic signed [ACC_WIDTH-1:0] inc_p1;
  logic signed [ACC_WIDTH-1:0] acc_p2;
  logic signed [ACC_WIDTH-1:0] acc_nxt;
  logic                        ovf_nxt;
  logic                        clear_acc;

  assign accept_p0 = bus.in_valid && in_ready_r;
  assign clear_acc = (state == HOLD) && bus.out_ready;

  spike_mask_adder #(
    .N_SYN   (N_SYN),
    .W_WIDTH (W_WIDTH)
  ) u_mask_adder (
    .spike_in (bus.spike_in),
    .weight   (bus.weight),
    .psum     (psum_p0)
  );

  // Timestep controller; in_ready and out_valid are registered and depend
  // only on state, so out_ready never reaches in_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ACCUM;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept_p0 && bus.in_last) begin
            state      <= FLUSH;
            in_ready_r <= 1'b0;
          end
        end
        FLUSH: begin
          state       <= HOLD;
          out_valid_r <= 1'b1;
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= ACCUM;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= ACCUM;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // ---- stage 0 -> 1: masked lane sum ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      psum_p1 <= '0;
    end else begin
      vld_p1  <= accept_p0;
      last_p1 <= accept_p0 && bus.in_last;
      psum_p1 <= psum_p0;
    end
  end

  // FLUSH is only reachable by accepting a last beat, so its psum is the
  // one sitting in stage 1 during FLUSH.
  always_ff @(posedge clk) begin
    if (!rst && state == FLUSH) begin
      assert (last_p1 && vld_p1);
    end
  end

  assign inc_p1 = ACC_WIDTH'(psum_p1);

`ifdef SPIKE_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max_bits(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min_bits(ACC_WIDTH));

  logic sat_p2;

  // One guard bit exposes signed overflow: the two top bits disagree.
  function automatic logic signed [ACC_WIDTH-1:0] sat_add(
    input  logic signed [ACC_WIDTH-1:0] a,
    input  logic signed [ACC_WIDTH-1:0] b,
    output logic                        ovf
  );
    logic signed [ACC_WIDTH:0] wide;
    wide = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
    ovf  = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    if (ovf) begin
      return wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return wide[ACC_WIDTH-1:0];
  endfunction

  always_comb begin
    ovf_nxt = 1'b0;
    acc_nxt = sat_add(acc_p2, inc_p1, ovf_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      sat_p2 <= 1'b0;
    end else if (vld_p1) begin
      sat_p2 <= sat_p2 | ovf_nxt;
    end
  end

  assign bus.out_sat = sat_p2;
`else
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    return a + b;
  endfunction

  always_comb begin
    ovf_nxt = 1'b0;
    acc_nxt = wrap_add(acc_p2, inc_p1);
  end

  assign bus.out_sat = ovf_nxt;
`endif

  // ---- stage 1 -> 2: timestep accumulator ----
  always_ff @(posedge clk) begin
    if (rst || clear_acc) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= acc_nxt;
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = acc_p2;

endmodule

// File: tb/tb_spike_mac_accum.sv
module tb_spike_mac_accum;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spike_mac_accum_if #(.N_SYN(4), .W_WIDTH(32), .ACC_WIDTH(40)) a ();
  spike_mac_accum_if #(.N_SYN(4), .W_WIDTH(32), .ACC_WIDTH(34)) b ();

  spike_mac_accum #(.N_SYN(4), .W_WIDTH(32), .ACC_WIDTH(40)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  spike_mac_accum #(.N_SYN(4), .W_WIDTH(32), .ACC_WIDTH(34)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  spk;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
    longint      exp_sum;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Presents one beat on bus a and returns 1ns after the accepting edge.
  task automatic beat(input logic [3:0] spk, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] w2, input logic [31:0] w3, input logic last);
    a.in_valid = 1'b1;
    a.in_last  = last;
    a.spike_in = spk;
    a.weight   = {w3, w2, w1, w0};
    chk("in_ready_on_beat", longint'(a.in_ready), 1);
    @(posedge clk); #1;
    a.in_valid = 1'b0;
    a.in_last  = 1'b0;
    a.spike_in = '0;
  endtask

  // Called 1ns after the last beat's accepting edge (cycle t+1).
  task automatic expect_result(input string tag, input longint exp_sum, input int stall);
    longint held;
    chk({tag, "_valid_t1"}, longint'(a.out_valid), 0);
    chk({tag, "_ready_flush"}, longint'(a.in_ready), 0);
    @(posedge clk); #1;
    chk({tag, "_valid_t2"}, longint'(a.out_valid), 1);
    held = longint'($signed(a.out_sum));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, longint'(a.out_valid), 1);
      chk({tag, "_hold_ready"}, longint'(a.in_ready), 0);
      chk({tag, "_hold_stable"}, longint'($signed(a.out_sum)), held);
    end
    chk({tag, "_sum"}, longint'($signed(a.out_sum)), exp_sum);
    chk({tag, "_sat"}, longint'(a.out_sat), 0);
    a.out_ready = 1'b1;
    @(posedge clk); #1;
    a.out_ready = 1'b0;
    chk({tag, "_valid_after_hs"}, longint'(a.out_valid), 0);
    chk({tag, "_ready_after_hs"}, longint'(a.in_ready), 1);
    chk({tag, "_sum_cleared"}, longint'($signed(a.out_sum)), 0);
  endtask

  initial begin
    longint exp_ovf_sum;
    logic   exp_ovf_sat;

    vecs[0] = '{4'b0101, 32'd1, 32'd2, 32'd3, 32'd4, 64'sd4};
    vecs[1] = '{4'b0000, 32'd5, 32'd6, 32'd7, 32'd8, 64'sd0};
    vecs[2] = '{4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'hFFFF_FFFC, -64'sd10};
    vecs[3] = '{4'b1010, 32'd100, 32'd200, 32'd300, 32'd400, 64'sd600};
    vecs[4] = '{4'b1000, 32'd1, 32'd1, 32'd1, 32'h8000_0000, -64'sd2147483648};
    vecs[5] = '{4'b0110, 32'd50, 32'hFFFF_FFFF, 32'd5, 32'd70, 64'sd4};

    a.in_valid = 1'b0; a.in_last = 1'b0; a.spike_in = '0; a.weight = '0; a.out_ready = 1'b0;
    b.in_valid = 1'b0; b.in_last = 1'b0; b.spike_in = '0; b.weight = '0; b.out_ready = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", longint'(a.in_ready), 1);
    chk("reset_out_valid", longint'(a.out_valid), 0);
    chk("reset_out_sum", longint'($signed(a.out_sum)), 0);
    chk("reset_out_sat", longint'(a.out_sat), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-beat timesteps from the table.
    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].spk, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3, 1'b1);
      expect_result($sformatf("vec%0d", i), vecs[i].exp_sum, 0);
    end

    // Three back-to-back beats, then 5 cycles of backpressure.
    beat(4'b1111, 32'd10, 32'd10, 32'd10, 32'd10, 1'b0);
    beat(4'b1111, 32'd10, 32'd10, 32'd10, 32'd10, 1'b0);
    beat(4'b1111, 32'd10, 32'd10, 32'd10, 32'd10, 1'b1);
    expect_result("multibeat_bp", 120, 5);

    // Accumulator must have been cleared by the handshake.
    beat(4'b0001, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    expect_result("after_bp", 7, 0);

    // Signed accumulation across beats.
    beat(4'b1000, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFB, 1'b0);
    beat(4'b0001, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1);
    expect_result("signed", 2, 0);

    // Reset while in FLUSH discards the timestep.
    beat(4'b1111, 32'd10, 32'd10, 32'd10, 32'd10, 1'b0);
    beat(4'b0001, 32'd3, 32'd0, 32'd0, 32'd0, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", longint'(a.out_valid), 0);
    chk("midrst_in_ready", longint'(a.in_ready), 1);
    chk("midrst_out_sum", longint'($signed(a.out_sum)), 0);
    @(posedge clk); #1;
    chk("midrst_no_late_result", longint'(a.out_valid), 0);
    beat(4'b0010, 32'd0, 32'd9, 32'd0, 32'd0, 1'b1);
    expect_result("after_midrst", 9, 0);

    // Overflow on the 34-bit instance.
`ifdef SPIKE_MAC_SAT_EN
    exp_ovf_sum = (64'sd1 <<< 33) - 64'sd1;
    exp_ovf_sat = 1'b1;
`else
    exp_ovf_sum = -64'sd8;
    exp_ovf_sat = 1'b0;
`endif
    b.in_valid = 1'b1;
    b.spike_in = 4'b1111;
    b.weight   = {4{32'h7FFF_FFFF}};
    b.in_last  = 1'b0;
    chk("ovf_in_ready_b1", longint'(b.in_ready), 1);
    @(posedge clk); #1;
    b.in_last = 1'b1;
    chk("ovf_in_ready_b2", longint'(b.in_ready), 1);
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
    chk("ovf_valid_t1", longint'(b.out_valid), 0);
    @(posedge clk); #1;
    chk("ovf_valid_t2", longint'(b.out_valid), 1);
    chk("ovf_sum", longint'($signed(b.out_sum)), exp_ovf_sum);
    chk("ovf_sat", longint'(b.out_sat), longint'(exp_ovf_sat));
    b.out_ready = 1'b1;
    @(posedge clk); #1;
    b.out_ready = 1'b0;
    chk("ovf_sat_cleared", longint'(b.out_sat), 0);
    chk("ovf_sum_cleared", longint'($signed(b.out_sum)), 0);
    chk("ovf_in_ready_after", longint'(b.in_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_mac_accum.md
# spike_mac_accum

Parametrised spike-gated multiply-accumulate unit for the neuron core. It accepts beats of `N_SYN` binary spikes with their synaptic weights, gates each weight by its spike, and sums the surviving weights through a registered adder stage. It accumulates beats across one timestep and, on the last beat, hands the membrane-current contribution to the neuron update stage over a valid/ready handshake.

## Interface
Clock and reset: one clock; reset is synchronous and active-high.

Parameters:
- `N_SYN`, 4: synapses per beat, at least 1.
- `W_WIDTH`, 32: weight width; signed two's complement.
- `ACC_WIDTH`, 40: accumulator and result width; at least `W_WIDTH + clog2(N_SYN)`.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: input beat valid.
- `in_ready`, output, 1: unit can accept a beat.
- `in_last`, input, 1: beat is the last of the timestep.
- `spike_in`, input, `N_SYN`: bit i gates lane i.
- `weight`, input, `N_SYN*W_WIDTH`: lane i weight is bits `[i*W_WIDTH +: W_WIDTH]`.
- `out_valid`, output, 1: result available.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, `ACC_WIDTH`: signed accumulated sum for the timestep.
- `out_sat`, output, 1: accumulator saturated during this timestep.

## Operation
- **Beat acceptance:** a beat is accepted when `in_valid && in_ready`.
- **Stage 1 (registered):** `psum = Σ (spike_in[i] ? sext(weight_i) : 0)`, computed at width `W_WIDTH + clog2(N_SYN)`. An all-zero spike vector contributes 0. The stage also registers a valid bit and the `last` flag.
- **Stage 2:** when the stage-1 valid bit is set, `acc <= acc + sext(psum)`, computed at width `ACC_WIDTH`.
- **State machine:**
  - ACCUM: `in_ready = 1`. Accepting a beat with `in_last` moves to FLUSH.
  - FLUSH: `in_ready = 0`. The final psum is added. Always moves to HOLD after 1 cycle.
  - HOLD: `out_valid = 1`, `in_ready = 0`. On `out_ready`, clear `acc` and `out_sat` and move to ACCUM.
- **Result stability:** `out_sum` equals `acc` and holds stable while HOLD waits for `out_ready`.
- **Simultaneous events:** `out_ready` asserted in the same cycle HOLD is entered completes the handshake in that cycle.
- **`in_last` without spikes:** still produces a result. Example: a single beat with all spikes 0 yields `out_sum = 0`.
- **Reset:** applies in any state, including mid-timestep. State becomes ACCUM, and `acc`, stage-1 registers, `out_valid` and `out_sat` all become 0. Beats in flight are discarded.
- **Reset values:** `in_ready = 1` (ACCUM), `out_valid = 0`, `out_sum = 0`, `out_sat = 0`.

## Timing
- Throughput: 1 beat per cycle in ACCUM.
- Latency: a last beat accepted at cycle t gives `out_valid = 1` at t+2.
- After the output handshake at cycle h, `in_ready = 1` at cycle h+1.
- Minimum timestep period: beats + 2 cycles, assuming no backpressure.
- `out_sum` and `out_sat` are registered outputs; there is no combinational path from `in_*` to `out_*`.
- `in_ready` depends only on state; it has no path from `out_ready`.

## Configuration
- Macro: `SPIKE_MAC_SAT_EN`.
- When defined:
  - Stage-2 addition detects signed overflow.
  - On overflow, `acc` clamps to `2^(ACC_WIDTH-1)-1` or `-2^(ACC_WIDTH-1)`.
  - `out_sat` becomes 1 and stays sticky until the output handshake or reset.
- When undefined:
  - The addition wraps modulo `2^ACC_WIDTH`.
  - `out_sat` is tied to 0.

## Structure
- Package `spike_mac_pkg` holds:
  - the state enum (`ACCUM`, `FLUSH`, `HOLD`);
  - the psum-width function `W_WIDTH + clog2(N_SYN)`;
  - the saturation-limit constants.
- Sub-module `spike_mask_adder`: combinational spike masking plus an adder tree, parametrised by `N_SYN` and `W_WIDTH`. `spike_mac_accum` instantiates it once and registers its output as stage 1.

## Test plan
All scenarios use the defaults (`N_SYN = 4`, `W_WIDTH = 32`, `ACC_WIDTH = 40`) unless stated otherwise.
1. Lane gating: one beat, `spike_in = 4'b0101`, weights lane0..3 = 1, 2, 3, 4, `in_last = 1` → `out_valid` at t+2 with `out_sum = 4`; `out_sat = 0`.
2. Multi-beat accumulation: three back-to-back beats, `spike_in = 4'b1111`, all weights 10, `in_last` on the third → `in_ready` stays 1 for all three beats, then `out_sum = 120`.
3. Backpressure: `out_ready = 0` for 5 cycles after the result is ready → `out_valid` held at 1, `out_sum` stable, `in_ready = 0`. On release, the next single beat of lane0 = 7 (`spike_in = 4'b0001`) gives `out_sum = 7`, showing the accumulator was cleared.
4. Signed weights: beat 1 has lane3 = -5 with `spike_in = 4'b1000`; beat 2 has lane0 = 7 with `spike_in = 4'b0001` and `in_last` → `out_sum = 2`.
5. Overflow, with `ACC_WIDTH = 34`: two beats of all lanes = `0x7FFFFFFF`, `spike_in = 4'b1111` → with `SPIKE_MAC_SAT_EN`, `out_sum = 2^33-1` and `out_sat = 1`; without it, `out_sum = -8` and `out_sat = 0`.
6. Reset mid-timestep: `rst` asserted in FLUSH → next cycle `out_valid = 0`, `in_ready = 1`. A following single beat of lane1 = 9 gives `out_sum = 9`, with no earlier beats included.
